// File: rtl/ac2m_pkg.sv
// ac2m_pkg: FSM states, width helpers and saturation helpers for ac2_multi
package ac2m_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic int la_w(int m, int pa);
    return $clog2(m) + pa + 1;
  endfunction
  function automatic int aw_w(int la, int nw);
    return la + nw;
  endfunction
  function automatic logic signed [63:0] sat_val(logic signed [63:0] v, int ow);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic sat_ovf(logic signed [63:0] v, int ow);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    return v > hi || v < lo;
  endfunction
endpackage

// File: rtl/ac2_multi_if.sv
// ac2_multi_if: slice input and registered result bundle for ac2_multi
interface ac2_multi_if import ac2m_pkg::*; #(
  parameter int NCH = 4,
  parameter int LA = la_w(16, 8),
  parameter int OW = 16
);
  logic valid, first, cl_en;
  logic [NCH*LA-1:0] in_ac2;
  logic [NCH*OW-1:0] out_ac2;
  logic out_valid, busy;
  logic [NCH-1:0] ovf;
  modport master(output valid, first, cl_en, in_ac2, input out_ac2, out_valid, ovf, busy);
  modport slave(input valid, first, cl_en, in_ac2, output out_ac2, out_valid, ovf, busy);
endinterface

// File: rtl/ac2m_lane.sv
// ac2m_lane: per-lane slice accumulator and output register; AC2M_SAT_EN selects saturation over wrap
module ac2m_lane import ac2m_pkg::*; #(
  parameter int LA = 13,
  parameter int AW = 21,
  parameter int OW = 16,
  parameter int PW = 4,
  parameter int S = 2
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  input logic ld,
  input logic zero,
  input logic done,
  input logic signed [LA-1:0] lane_in,
  output logic signed [OW-1:0] out,
  output logic ovf
);
  logic signed [AW-1:0] acc_q, acc_d, acc_base, acc_nxt;
  logic signed [OW-1:0] out_q, out_d;
  logic ovf_q, ovf_d;
  always_comb begin
    acc_base = zero ? '0 : acc_q;
    acc_nxt = (acc_base >>> PW) + (AW'(lane_in) <<< (PW * (S - 1)));
    acc_d = clr ? '0 : ld ? acc_nxt : acc_q;
`ifdef AC2M_SAT_EN
    out_d = done ? OW'(sat_val(64'(acc_nxt), OW)) : out_q;
    ovf_d = done ? sat_ovf(64'(acc_nxt), OW) : ovf_q;
`else
    out_d = done ? acc_nxt[OW-1:0] : out_q;
    ovf_d = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end
  assign out = out_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/ac2_multi.sv
// ac2_multi: multi-lane slice-serial accumulator with shared slice FSM; define AC2M_SAT_EN for saturating output
module ac2_multi import ac2m_pkg::*; #(
  parameter int M = 16,
  parameter int Pa = 8,
  parameter int Pw = 4,
  parameter int NW = 8,
  parameter int NCH = 4,
  parameter int OW = 16,
  localparam int LA = la_w(M, Pa),
  localparam int AW = aw_w(LA, NW),
  localparam int S = NW / Pw,
  localparam int CW = $clog2(S) + 1
) (
  input logic clk,
  input logic rst_n,
  ac2_multi_if.slave bus
);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base;
  logic start, accept, last, load, out_valid_q;
  logic [NCH*OW-1:0] out_w;
  logic [NCH-1:0] ovf_w;
  always_comb begin
    start = bus.valid & bus.first;
    accept = start | (bus.valid & (state_q == ACC));
    cnt_base = start ? '0 : cnt_q;
    last = accept & (cnt_base == CW'(S - 1));
    load = last & ~bus.cl_en;
    cnt_d = (bus.cl_en | last) ? '0 : accept ? cnt_base + CW'(1) : cnt_q;
    state_d = bus.cl_en ? IDLE : last ? DONE : accept ? ACC : (state_q == DONE) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_valid_q <= load;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    ac2m_lane #(.LA(LA), .AW(AW), .OW(OW), .PW(Pw), .S(S)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .clr(bus.cl_en),
      .ld(accept),
      .zero(start),
      .done(load),
      .lane_in(bus.in_ac2[i*LA +: LA]),
      .out(out_w[i*OW +: OW]),
      .ovf(ovf_w[i])
    );
  end
  assign bus.out_ac2 = out_w;
  assign bus.ovf = ovf_w;
  assign bus.out_valid = out_valid_q;
  assign bus.busy = state_q == ACC;
endmodule

// File: doc/ac2_multi.md
# ac2_multi

Parametrised, multi-lane successor to the serial-MAC AC2 stage. It accumulates signed partial products slice by slice, Pw weight bits per cycle, LSB slice first, for NCH lanes that share one controller. A slice counter and FSM detect word completion, and a separate output register holds each finished result. It sits between the per-lane negation stage and the output/requantisation logic of the noAC3 serial MAC array.

## Interface
Parameters:
- M, 16: accumulation depth. Sets the input growth $clog2(M).
- Pa, 8: activation operand width.
- Pw, 4: weight bits consumed per slice.
- NW, 8: total weight width. Must be a multiple of Pw. S = NW/Pw slices per word.
- NCH, 4: number of lanes.
- OW, 16: output width per lane, signed.
- Derived: LA = $clog2(M)+Pa+1 (lane input width, signed). AW = LA+NW (accumulator width).

Ports:
- clk, in, 1: clock. All state updates on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- valid, in, 1: the current slice on in_ac2 is presented.
- first, in, 1: qualifies valid. Marks slice 0 of a word.
- cl_en, in, 1: synchronous clear of the accumulation state.
- in_ac2, in, NCH*LA: lane i occupies bits [i*LA +: LA]. Two's complement; the MSB slice arrives already negated upstream.
- out_ac2, out, NCH*OW: lane i occupies bits [i*OW +: OW]. Registered result.
- out_valid, out, 1: one-cycle pulse when out_ac2 updates.
- ovf, out, NCH: per-lane overflow flag, updated together with out_ac2.
- busy, out, 1: high while a word is partially accumulated.

## Operation
- FSM states are IDLE, ACC and DONE. busy = (state == ACC).
- Slice counter cnt has width $clog2(S)+1.
- Per-lane update on an accepted slice: acc <= (acc >>> Pw) + (sext(in) << Pw*(S-1)).
  - Slice 0 uses acc = 0 in place of the stored value.
  - The result is exact with no bit loss. After S slices, acc = sum over k of in_k * 2^(Pw*k).
- Slice acceptance:
  - In IDLE, only valid & first is accepted; valid without first is ignored.
  - In ACC, valid is accepted. valid & first restarts the word as slice 0 and discards the partial result.
  - valid low in ACC stalls: acc and cnt hold.
- Transitions:
  - IDLE to ACC on slice 0 (cnt <= 1).
  - ACC stays in ACC while cnt < S-1 after the increment.
  - On the final slice (cnt == S-1), the next state is DONE and the lane results load into the output register.
  - With S == 1, slice 0 is also the final slice, so IDLE goes directly to DONE.
  - From DONE: valid & first is accepted as slice 0 of the next word (back-to-back, no bubble); otherwise the next state is IDLE.
- Output register: out_ac2 and ovf change only on word completion and otherwise hold their value.
- cl_en:
  - Takes priority over valid.
  - Zeroes acc and cnt and forces IDLE.
  - Does not touch out_ac2 or ovf.
  - A completion in the same cycle as cl_en is discarded: no out_valid.
- Reset (rst_n = 0 at an edge):
  - All acc, cnt, out_ac2 and ovf go to 0.
  - out_valid = 0, busy = 0, state = IDLE.
  - Reset mid-word discards the partial word.

## Timing
- Slice throughput is 1 per cycle. A word takes S accepted cycles.
- Latency: out_valid and the new out_ac2 appear in the cycle after the final slice is sampled.
- out_valid is exactly 1 cycle wide per completed word.
- No backpressure. The downstream consumer must take out_ac2 before the next completion, which can come S cycles later at the earliest.

## Configuration
- AC2M_SAT_EN defined:
  - Each lane's AW-bit result saturates to the signed OW range [-2^(OW-1), 2^(OW-1)-1].
  - ovf[i] = 1 when lane i clipped.
- AC2M_SAT_EN undefined:
  - out_ac2 lane i = acc[OW-1:0] (two's-complement wrap).
  - ovf is tied to 0.

## Structure
- Package ac2m_pkg holds:
  - the FSM state enum;
  - width helper functions for LA and AW;
  - the saturation helper function.
- Sub-module ac2m_lane holds the per-lane accumulator and output conversion. It is instantiated NCH times by a generate loop.
- The FSM and counter live once, in the top module ac2_multi.

## Test plan
All scenarios use M=16, Pa=8, Pw=4, NW=8, NCH=4, OW=16, giving LA=13 and S=2.
- Basic word: lane0 receives 3 (first), then -2 -> out_valid 1 cycle later with lane0 = -29 and ovf = 0. Other lanes fed 0 -> output 0.
- Back-to-back: two words on 4 consecutive valid cycles, lane0 (1, 1) then (5, 0) -> out_valid pulses at cycles 3 and 5 with lane0 = 17, then 5.
- Stall and restart: slice0 = 7, then 2 idle cycles -> acc holds. Then first with 9 and a following 1 -> result 25; the 7 is discarded.
- Clear priority: cl_en asserted together with the final slice -> no out_valid, busy = 0, out_ac2 keeps its previous value.
- Saturation: lane0 receives 4095, 4095 (sum 69615):
  - with AC2M_SAT_EN -> 32767 and ovf[0] = 1;
  - without AC2M_SAT_EN -> 4079 and ovf[0] = 0.
- Reset mid-word: rst_n low after slice 0 -> all outputs 0 next cycle, and the following first-tagged word completes correctly.
